imem_loader: RTL and testbench

Program loader for the 8-bit processor's instruction memory. Accepts a framed byte stream over a valid/ready handshake: a length byte, N instruction bytes, then an XOR checksum byte. It writes each instruction byte into consecutive instruction-memory locations starting at index 0. It is the write-side counterpart of the instruction memory's index-driven read/decode path, and fills the array before the core starts fetching.

---
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: loads a framed byte stream (length, N bytes, XOR checksum)
// into instruction memory starting at index 0.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             one-cycle pulse, begins a load when idle
//   in_valid/in_data  byte stream input, accepted when in_ready is high
//   in_ready          loader accepts a byte this cycle (state only)
//   wr_en/addr/data   instruction-memory write port, 1-cycle latency
//   busy              load in progress
//   done/error        sticky result of the last load
//   loaded_count      bytes written by the current/last load
module imem_loader #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] loaded_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  // Idle count that triggers the abort on the next empty cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] remain, remain_nx;
  logic [7:0] acc, acc_nx;
  logic [7:0] idle, idle_nx;
  logic [7:0] cnt_nx;
  logic       busy_nx, done_nx, error_nx;
  logic       wr_en_nx;
  logic [7:0] wr_addr_nx, wr_data_nx;
  logic       accept;

  assign in_ready = (state != S_IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      remain       <= 8'd0;
      acc          <= 8'd0;
      idle         <= 8'd0;
      loaded_count <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= 8'd0;
      wr_data      <= 8'd0;
    end else begin
      state        <= state_nx;
      remain       <= remain_nx;
      acc          <= acc_nx;
      idle         <= idle_nx;
      loaded_count <= cnt_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      error        <= error_nx;
      wr_en        <= wr_en_nx;
      wr_addr      <= wr_addr_nx;
      wr_data      <= wr_data_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    remain_nx  = remain;
    acc_nx     = acc;
    idle_nx    = idle;
    cnt_nx     = loaded_count;
    busy_nx    = busy;
    done_nx    = done;
    error_nx   = error;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_LEN;
          done_nx  = 1'b0;
          error_nx = 1'b0;
          cnt_nx   = 8'd0;
          acc_nx   = 8'd0;
          idle_nx  = 8'd0;
          busy_nx  = 1'b1;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (in_data == 8'd0) begin
            state_nx = S_IDLE;
            error_nx = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            remain_nx = in_data;
            state_nx  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = loaded_count;
          wr_data_nx = in_data;
          cnt_nx     = loaded_count + 8'd1;
          acc_nx     = acc ^ in_data;
          remain_nx  = remain - 8'd1;
          if (remain == 8'd1)
            state_nx = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
          if (in_data == acc)
            done_nx = 1'b1;
          else
            error_nx = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Watchdog on a stalled stream while busy.
    if (state != S_IDLE) begin
      if (accept) begin
        idle_nx = 8'd0;
      end else if (idle == TO_LAST) begin
        state_nx = S_IDLE;
        error_nx = 1'b1;
        busy_nx  = 1'b0;
        idle_nx  = 8'd0;
      end else begin
        idle_nx = idle + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
// Writes are predicted into a queue and checked by a monitor.
module tb_imem_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] loaded_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  imem_loader #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .loaded_count (loaded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every observed write must match the queue head.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      logic [15:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%h/%h want=none",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          bad++;
          $display("FAIL write got=%h/%h want=%h/%h",
                   wr_addr, wr_data, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_end(input string nm, input logic d,
                           input logic e, input logic [7:0] c);
    total++;
    if ({busy, done, error, loaded_count} !== {1'b0, d, e, c}) begin
      bad++;
      $display("FAIL %s_flags got b=%b d=%b e=%b c=%0d want b=0 d=%b e=%b c=%0d",
               nm, busy, done, error, loaded_count, d, e, c);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_pending got=%0d want=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, wr_en, busy, done, error, loaded_count} !== 13'd0) begin
      bad++;
      $display("FAIL reset got r=%b w=%b b=%b d=%b e=%b c=%0d want 0",
               in_ready, wr_en, busy, done, error, loaded_count);
    end
  endtask

  task automatic test_normal();
    pulse_start();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL normal_busy got b=%b r=%b want 1/1", busy, in_ready);
    end
    send_byte(8'h03);
    exp_q.push_back({8'd0, 8'hA5});
    send_byte(8'hA5);
    exp_q.push_back({8'd1, 8'h3C});
    send_byte(8'h3C);
    exp_q.push_back({8'd2, 8'h0F});
    send_byte(8'h0F);
    send_byte(8'h96);
    check_end("normal", 1'b1, 1'b0, 8'd3);
  endtask

  task automatic test_restart();
    // start while done is still high
    pulse_start();
    total++;
    if ({busy, done, error, loaded_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL restart got b=%b d=%b e=%b c=%0d want 1 0 0 0",
               busy, done, error, loaded_count);
    end
    send_byte(8'h01);
    exp_q.push_back({8'd0, 8'h5A});
    send_byte(8'h5A);
    send_byte(8'h5A);
    check_end("restart", 1'b1, 1'b0, 8'd1);
  endtask

  task automatic test_bad_chk();
    pulse_start();
    send_byte(8'h03);
    exp_q.push_back({8'd0, 8'hA5});
    send_byte(8'hA5);
    exp_q.push_back({8'd1, 8'h3C});
    send_byte(8'h3C);
    exp_q.push_back({8'd2, 8'h0F});
    send_byte(8'h0F);
    send_byte(8'h97);
    check_end("badchk", 1'b0, 1'b1, 8'd3);
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_byte(8'h00);
    check_end("zerolen", 1'b0, 1'b1, 8'd0);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL zerolen_ready got=%b want=0", in_ready);
    end
  endtask

  task automatic test_gaps();
    pulse_start();
    send_byte(8'h03);
    exp_q.push_back({8'd0, 8'hA5});
    send_byte(8'hA5);
    gap(3);
    exp_q.push_back({8'd1, 8'h3C});
    send_byte(8'h3C);
    gap(3);
    exp_q.push_back({8'd2, 8'h0F});
    send_byte(8'h0F);
    gap(3);
    send_byte(8'h96);
    check_end("gaps", 1'b1, 1'b0, 8'd3);
  endtask

  task automatic test_timeout();
    pulse_start();
    send_byte(8'h03);
    exp_q.push_back({8'd0, 8'hA5});
    send_byte(8'hA5);
    exp_q.push_back({8'd1, 8'h3C});
    send_byte(8'h3C);
    gap(3);
    total++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early got b=%b e=%b want 1/0", busy, error);
    end
    gap(1);
    check_end("timeout", 1'b0, 1'b1, 8'd2);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'h05);
    exp_q.push_back({8'd0, 8'hB0});
    send_byte(8'hB0);
    // second byte's write is in flight and gets cut by the reset
    send_byte(8'hB1);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, wr_en, busy, done, error, loaded_count} !== 13'd0) begin
      bad++;
      $display("FAIL midreset got r=%b w=%b b=%b d=%b e=%b c=%0d want 0",
               in_ready, wr_en, busy, done, error, loaded_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_start();
    send_byte(8'h02);
    exp_q.push_back({8'd0, 8'h11});
    send_byte(8'h11);
    exp_q.push_back({8'd1, 8'h22});
    send_byte(8'h22);
    send_byte(8'h33);
    check_end("midreset_reload", 1'b1, 1'b0, 8'd2);
  endtask

  task automatic test_start_in_load();
    pulse_start();
    send_byte(8'h03);
    exp_q.push_back({8'd0, 8'hA5});
    send_byte(8'hA5);
    start = 1'b1;
    exp_q.push_back({8'd1, 8'h3C});
    send_byte(8'h3C);
    start = 1'b0;
    exp_q.push_back({8'd2, 8'h0F});
    send_byte(8'h0F);
    send_byte(8'h96);
    check_end("startbusy", 1'b1, 1'b0, 8'd3);
  endtask

  task automatic test_back_to_back();
    logic [7:0] x;
    x = 8'h00;
    pulse_start();
    send_byte(8'h08);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      x = x ^ b;
      exp_q.push_back({8'(i), b});
      send_byte(b);
    end
    send_byte(x);
    check_end("b2b", 1'b1, 1'b0, 8'd8);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_normal();
    test_restart();
    test_bad_chk();
    test_zero_len();
    test_gaps();
    test_timeout();
    test_reset_mid();
    test_start_in_load();
    test_back_to_back();
    gap(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
